// File: rtl/store_buffer_pkg.sv
// Shared constants and entry layout for the memory-stage store buffer.
package store_buffer_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int WE_W    = DATA_W / 8;
  localparam int WADDR_W = ADDR_W - 2;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // One pending dcache write: word address, lane-aligned data, byte enables.
  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  din;
    logic [WE_W-1:0]    we;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle between execute / dcache / hazard unit and the store buffer.
interface store_buffer_if;
  import store_buffer_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid and its payload must hold until that edge, and ready
  // never depends combinationally on valid from the other side.
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [2:0]        st_funct3;
  logic              st_misaligned;

  logic              dc_req_valid;
  logic              dc_req_ready;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_din;
  logic [WE_W-1:0]   dc_we;

  logic              ld_check_en;
  logic [ADDR_W-1:0] ld_check_addr;
  logic              ld_conflict;
  logic              sb_empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, dc_req_ready,
           ld_check_en, ld_check_addr,
    output st_ready, st_misaligned, dc_req_valid, dc_addr, dc_din, dc_we,
           ld_conflict, sb_empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_funct3, dc_req_ready,
           ld_check_en, ld_check_addr,
    input  st_ready, st_misaligned, dc_req_valid, dc_addr, dc_din, dc_we,
           ld_conflict, sb_empty
  );

endinterface

// File: rtl/store_buffer_st_align.sv
// Combinational store lane alignment: byte enables, replicated data, legality.
module store_buffer_st_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]        off_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] din_o,
  output logic [WE_W-1:0]   we_o,
  output logic              illegal_o
);

  always_comb begin
    din_o     = '0;
    we_o      = '0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_SB: begin
        we_o  = 4'b0001 << off_i;
        din_o = {4{data_i[7:0]}};
      end
      F3_SH: begin
        if (off_i[0]) begin
          illegal_o = 1'b1;
        end else begin
          we_o  = 4'b0011 << off_i;
          din_o = {2{data_i[15:0]}};
        end
      end
      F3_SW: begin
        if (off_i != 2'b00) begin
          illegal_o = 1'b1;
        end else begin
          we_o  = 4'hF;
          din_o = data_i;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns stores, queues them FIFO and drains to the dcache write
// port; also flags loads that touch a word with a pending store.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  store_buffer_if.slave    bus,
  output logic [CNT_W-1:0] dbg_count_o,
  output logic [PTR_W-1:0] dbg_wr_ptr_o,
  output logic [PTR_W-1:0] dbg_rd_ptr_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sb_entry_t          mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               misaligned_q, misaligned_d;

  logic [DATA_W-1:0]  al_din;
  logic [WE_W-1:0]    al_we;
  logic               al_illegal;
  logic               st_fire, enq, deq;
  sb_entry_t          new_entry;
  logic [WADDR_W-1:0] ld_waddr;
  logic [DEPTH-1:0]   hit;

  store_buffer_st_align u_align (
    .off_i     (bus.st_addr[1:0]),
    .funct3_i  (bus.st_funct3),
    .data_i    (bus.st_data),
    .din_o     (al_din),
    .we_o      (al_we),
    .illegal_o (al_illegal)
  );

  // Illegal stores still complete the handshake but never occupy a slot.
  assign st_fire   = bus.st_valid && bus.st_ready;
  assign enq       = st_fire && !al_illegal;
  assign deq       = bus.dc_req_valid && bus.dc_req_ready;
  assign new_entry = '{waddr: bus.st_addr[ADDR_W-1:2], din: al_din, we: al_we};

  assign bus.st_ready      = (count_q != FULL_CNT);
  assign bus.dc_req_valid  = (count_q != '0);
  assign bus.sb_empty      = (count_q == '0);
  assign bus.dc_addr       = {mem_q[rd_ptr_q].waddr, 2'b00};
  assign bus.dc_din        = mem_q[rd_ptr_q].din;
  assign bus.dc_we         = mem_q[rd_ptr_q].we;
  assign bus.st_misaligned = misaligned_q;

  // Word-granular compare; an entry leaving this cycle is still pending.
  assign ld_waddr = WADDR_W'(bus.ld_check_addr >> 2);

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid_q[i] && (mem_q[i].waddr == ld_waddr);
    end
  end

  assign bus.ld_conflict = bus.ld_check_en && (|hit);

  always_comb begin
    valid_d      = valid_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    misaligned_d = st_fire && al_illegal;
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (enq) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
      if (enq) begin
        mem_q[wr_ptr_q] <= new_entry;
      end
    end
  end

  assign dbg_count_o  = count_q;
  assign dbg_wr_ptr_o = wr_ptr_q;
  assign dbg_rd_ptr_o = rd_ptr_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drivers push expected dcache writes into a
// queue, a negedge monitor compares every presented write against the head.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int PTR_W = 1;
  localparam int CNT_W = 2;
  localparam int W     = 68;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if bus ();
  logic [CNT_W-1:0] dbg_count;
  logic [PTR_W-1:0] dbg_wr_ptr, dbg_rd_ptr;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_count_o  (dbg_count),
    .dbg_wr_ptr_o (dbg_wr_ptr),
    .dbg_rd_ptr_o (dbg_rd_ptr)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got;
  int n_checks  = 0;
  int n_errors  = 0;
  int mis_seen  = 0;
  int deq_cnt   = 0;
  int enq_total = 0;
  int acc_deq   = 0;
  int base;

  function automatic logic [W-1:0] pack(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] we);
    return {a, d, we};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.st_misaligned) mis_seen++;
      if (bus.dc_req_valid) begin
        got = {bus.dc_addr, bus.dc_din, bus.dc_we};
        if (exp_q.size() == 0) begin
          check("dc_unexpected_req", got, '0);
        end else begin
          check("dc_head", got, exp_q[0]);
          if (bus.dc_req_ready) begin
            void'(exp_q.pop_front());
            deq_cnt++;
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3, input bit legal,
                            input logic [31:0] e_addr, input logic [31:0] e_din,
                            input logic [3:0] e_we, input bit chk_probe);
    int t;
    bus.st_valid  = 1'b1;
    bus.st_addr   = addr;
    bus.st_data   = data;
    bus.st_funct3 = f3;
    t = 0;
    @(negedge clk);
    while (!bus.st_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.st_ready) begin
      check("st_accept_timeout", 1'b0, 1'b1);
      bus.st_valid = 1'b0;
      return;
    end
    if (chk_probe) check("ld_conflict_accepting_store", bus.ld_conflict, 1'b0);
    @(posedge clk);
    #1;
    acc_deq = deq_cnt;
    if (legal) begin
      exp_q.push_back(pack(e_addr, e_din, e_we));
      enq_total++;
    end
    bus.st_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !bus.sb_empty) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", (exp_q.size() == 0) && bus.sb_empty, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Simultaneous enqueue/dequeue vectors
  logic [31:0] v_addr [8] = '{32'h4000, 32'h4005, 32'h4006, 32'h4008,
                              32'h400C, 32'h400E, 32'h4010, 32'h4014};
  logic [31:0] v_data [8] = '{32'h01020304, 32'h000000C3, 32'h0000BEEF, 32'hCAFEF00D,
                              32'h12345678, 32'h0000009A, 32'hFFFF0001, 32'h55AA55AA};
  logic [2:0]  v_f3   [8] = '{F3_SW, F3_SB, F3_SH, F3_SW, F3_SB, F3_SB, F3_SH, F3_SW};
  logic [31:0] v_eadr [8] = '{32'h4000, 32'h4004, 32'h4004, 32'h4008,
                              32'h400C, 32'h400C, 32'h4010, 32'h4014};
  logic [31:0] v_edin [8] = '{32'h01020304, 32'hC3C3C3C3, 32'hBEEFBEEF, 32'hCAFEF00D,
                              32'h78787878, 32'h9A9A9A9A, 32'h00010001, 32'h55AA55AA};
  logic [3:0]  v_ewe  [8] = '{4'b1111, 4'b0010, 4'b1100, 4'b1111,
                              4'b0001, 4'b0100, 4'b0011, 4'b1111};

  // ---------------- main sequence ----------------
  initial begin
    bus.st_valid      = 1'b0;
    bus.st_addr       = '0;
    bus.st_data       = '0;
    bus.st_funct3     = '0;
    bus.dc_req_ready  = 1'b0;
    bus.ld_check_en   = 1'b0;
    bus.ld_check_addr = '0;

    #2;
    check("rst_dc_req_valid", bus.dc_req_valid, 1'b0);
    check("rst_st_misaligned", bus.st_misaligned, 1'b0);
    check("rst_ld_conflict", bus.ld_conflict, 1'b0);
    check("rst_sb_empty", bus.sb_empty, 1'b1);
    check("rst_st_ready", bus.st_ready, 1'b1);
    check("rst_count", dbg_count, 2'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lane alignment
    bus.dc_req_ready = 1'b1;
    send_store(32'h1003, 32'h000000AB, F3_SB, 1, 32'h1000, 32'hABABABAB, 4'b1000, 0);
    send_store(32'h1002, 32'h00001234, F3_SH, 1, 32'h1000, 32'h12341234, 4'b1100, 0);
    send_store(32'h1001, 32'h000001FF, F3_SB, 1, 32'h1000, 32'hFFFFFFFF, 4'b0010, 0);
    send_store(32'h1000, 32'hABCD5678, F3_SH, 1, 32'h1000, 32'h56785678, 4'b0011, 0);
    send_store(32'h1004, 32'hDEADBEEF, F3_SW, 1, 32'h1004, 32'hDEADBEEF, 4'b1111, 0);
    wait_drain();

    // Misaligned and illegal-funct3 stores
    send_store(32'h1001, 32'h11111111, F3_SW, 0, '0, '0, '0, 0);
    @(negedge clk);
    check("mis_sw_pulse", bus.st_misaligned, 1'b1);
    check("mis_sw_empty", bus.sb_empty, 1'b1);
    @(posedge clk);
    #1;
    check("mis_sw_pulse_end", bus.st_misaligned, 1'b0);
    send_store(32'h1003, 32'h00002222, F3_SH, 0, '0, '0, '0, 0);
    @(negedge clk);
    check("mis_sh_pulse", bus.st_misaligned, 1'b1);
    check("mis_sh_empty", bus.sb_empty, 1'b1);
    @(posedge clk);
    #1;
    check("mis_sh_pulse_end", bus.st_misaligned, 1'b0);
    send_store(32'h1000, 32'h00003333, 3'b100, 0, '0, '0, '0, 0);
    @(negedge clk);
    check("bad_f3_pulse", bus.st_misaligned, 1'b1);
    check("bad_f3_no_req", bus.dc_req_valid, 1'b0);
    @(posedge clk);
    #1;

    // Backpressure
    bus.dc_req_ready = 1'b0;
    send_store(32'h3000, 32'h11111111, F3_SW, 1, 32'h3000, 32'h11111111, 4'b1111, 0);
    send_store(32'h3005, 32'h00000022, F3_SB, 1, 32'h3004, 32'h22222222, 4'b0010, 0);
    check("bp_st_ready_full", bus.st_ready, 1'b0);
    check("bp_count_full", dbg_count, 2'd2);
    base = deq_cnt;
    fork
      send_store(32'h3008, 32'h00003333, F3_SH, 1, 32'h3008, 32'h33333333, 4'b0011, 0);
      begin
        repeat (3) @(posedge clk);
        #1 bus.dc_req_ready = 1'b1;
      end
    join
    check("bp_third_after_dequeue", (acc_deq - base) >= 1, 1'b1);
    wait_drain();

    // Simultaneous enqueue/dequeue at count 1
    for (int i = 0; i < 8; i++) begin
      send_store(v_addr[i], v_data[i], v_f3[i], 1, v_eadr[i], v_edin[i], v_ewe[i], 0);
      check("sim_count", dbg_count, 2'd1);
      check("sim_wr_ptr", dbg_wr_ptr, enq_total % DEPTH);
      check("sim_rd_ptr", dbg_rd_ptr, (enq_total + DEPTH - 1) % DEPTH);
    end
    wait_drain();

    // Load conflict probing
    bus.dc_req_ready  = 1'b0;
    bus.ld_check_en   = 1'b1;
    bus.ld_check_addr = 32'h2000;
    send_store(32'h2000, 32'hA5A5A5A5, F3_SW, 1, 32'h2000, 32'hA5A5A5A5, 4'b1111, 1);
    bus.ld_check_addr = 32'h2003;
    @(negedge clk);
    check("conf_same_word", bus.ld_conflict, 1'b1);
    bus.ld_check_addr = 32'h2004;
    @(negedge clk);
    check("conf_next_word", bus.ld_conflict, 1'b0);
    bus.ld_check_en   = 1'b0;
    bus.ld_check_addr = 32'h2000;
    @(negedge clk);
    check("conf_disabled", bus.ld_conflict, 1'b0);
    @(posedge clk);
    #1;
    bus.ld_check_en  = 1'b1;
    bus.dc_req_ready = 1'b1;
    @(negedge clk);
    check("conf_while_dequeuing", bus.ld_conflict, 1'b1);
    @(posedge clk);
    #1;
    check("conf_after_dequeue", bus.ld_conflict, 1'b0);
    check("conf_after_dequeue_empty", bus.sb_empty, 1'b1);

    // Reset mid-drain
    bus.dc_req_ready  = 1'b0;
    bus.ld_check_addr = 32'h6000;
    send_store(32'h6000, 32'h66666666, F3_SW, 1, 32'h6000, 32'h66666666, 4'b1111, 0);
    send_store(32'h6004, 32'h77777777, F3_SW, 1, 32'h6004, 32'h77777777, 4'b1111, 0);
    check("pre_rst_conflict", bus.ld_conflict, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dc_req_valid", bus.dc_req_valid, 1'b0);
    check("mid_rst_sb_empty", bus.sb_empty, 1'b1);
    check("mid_rst_st_ready", bus.st_ready, 1'b1);
    check("mid_rst_ld_conflict", bus.ld_conflict, 1'b0);
    exp_q.delete();
    enq_total = 0;
    base = deq_cnt;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.dc_req_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_no_stale_deq", deq_cnt - base, 0);
    check("post_rst_sb_empty", bus.sb_empty, 1'b1);
    check("post_rst_count", dbg_count, 2'd0);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_misaligned_pulses", mis_seen, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
